beat_generator: RTL

- Consumer end of the tempo interface: takes the 23-bit tempo period from the tempo selector and turns it into the sequencer's timebase.
- Counts clk cycles, emits a one-cycle beat_pulse every tempo+1 cycles, and advances a step index through one measure.
- Flags the measure wrap with measure_end.
- Drives the step sequencer / sample trigger logic downstream.

---
 rtl/beat_generator_pkg.sv | 21 ++
 rtl/beat_generator_timer.sv | 41 ++++
 rtl/beat_generator.sv | 86 ++++++++
 3 files changed

// File: rtl/beat_generator_pkg.sv
// Shared tempo encodings and beat FSM types for the
// tempo selector / beat generator pair.
package beat_generator_pkg;

  localparam int TEMPO_W = 23;
  localparam int STEPS   = 8;
  localparam int STEP_W  = $clog2(STEPS);

  localparam logic [TEMPO_W-1:0] BPM240 = 23'd2499999;
  localparam logic [TEMPO_W-1:0] BPM120 = 23'd4999999;
  localparam logic [TEMPO_W-1:0] BPM100 = 23'd5999999;
  localparam logic [TEMPO_W-1:0] BPM75  = 23'd7999999;

  localparam logic [TEMPO_W-1:0] RESET_PERIOD = BPM240;

  typedef enum logic {
    IDLE,
    RUN
  } beat_state_t;

endpackage

// File: rtl/beat_generator_timer.sv
// Beat interval timer: cycle counter plus the latched
// period it counts up to.
module beat_timer
  import beat_generator_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [TEMPO_W-1:0] tempo_i,
  output logic               tc_o
);

  logic [TEMPO_W-1:0] cnt_q, cnt_d;
  logic [TEMPO_W-1:0] period_q, period_d;

  assign tc_o = (cnt_q == period_q);

  // Tempo is only resampled at interval boundaries
  always_comb begin
    cnt_d    = cnt_q + TEMPO_W'(1);
    period_d = period_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i || tc_o) begin
      cnt_d    = '0;
      period_d = tempo_i;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q    <= '0;
      period_q <= RESET_PERIOD;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/beat_generator.sv
// Sequencer timebase: beat pulses every tempo+1 cycles and
// a step index walking through one measure.
module beat_generator
  import beat_generator_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               run,
  input  logic               restart,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               beat_pulse,
  output logic [STEP_W-1:0]  step,
  output logic               measure_end,
  output logic               running
);

  beat_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              beat_q, beat_d;
  logic              mend_q, mend_d;
  logic              tc;
  logic              t_clear;
  logic              t_load;

  assign t_clear = !run;
  assign t_load  = run && (state_q == IDLE || restart);

  beat_timer u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (t_clear),
    .load_i  (t_load),
    .tempo_i (tempo),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    beat_d  = 1'b0;
    mend_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        step_d = '0;
        if (run) begin
          state_d = RUN;
          beat_d  = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (restart) begin
          step_d = '0;
          beat_d = 1'b1;
        end else if (tc) begin
          step_d = step_q + STEP_W'(1);
          beat_d = 1'b1;
          mend_d = (step_q == STEP_W'(STEPS - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      beat_q  <= 1'b0;
      mend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      mend_q  <= mend_d;
    end
  end

  assign beat_pulse  = beat_q;
  assign step        = step_q;
  assign measure_end = mend_q;
  assign running     = (state_q == RUN);

endmodule
